nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits; legal values are multiples of 4 and at least 8.
REQ-002 SHALL derive the local constant N = WIDTH/4, the number of 4-bit slices; slice k covers bits [4k+3:4k].
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  request to begin an addition.
REQ-006 SHALL have port: a  input  WIDTH  operand A, sampled only on the accepting edge.
REQ-007 SHALL have port: b  input  WIDTH  operand B, sampled only on the accepting edge.
REQ-008 SHALL have port: cin  input  1  carry-in to slice 0, sampled only on the accepting edge.
REQ-009 SHALL have port: busy  output  1  high while slices are being processed.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: sum  output  WIDTH  registered result.
REQ-012 SHALL have port: cout  output  1  carry out of bit WIDTH-1.
REQ-013 SHALL have port: ovf  output  1  two's-complement overflow flag.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE; busy SHALL be 1 only in RUN and done SHALL be 1 only in DONE.
REQ-015 SHALL accept start only in IDLE or DONE ("accepting edge").
REQ-016 On an accepting edge, SHALL capture a, b and cin into internal registers.
REQ-017 On an accepting edge, SHALL clear sum, cout, ovf and the slice index to 0, and SHALL enter RUN.
REQ-018 SHALL ignore start while in RUN; captured operands SHALL NOT change during RUN.
REQ-019 On each RUN edge, SHALL compute one 4-bit slice: s = A[k] + B[k] + c, where c is the carry register.
REQ-020 On each RUN edge, SHALL write s[3:0] into sum bits [4k+3:4k], load the carry register with s[4], and increment k.
REQ-021 SHALL initialise the carry register to the captured cin on the accepting edge.
REQ-022 On the RUN edge with k = N-1, SHALL load cout with s[4].
REQ-023 On the RUN edge with k = N-1, SHALL set ovf = (carry into bit WIDTH-1) XOR s[4].
REQ-024 On the RUN edge with k = N-1, SHALL enter DONE.
REQ-025 Latency: done SHALL be high in the cycle following the Nth edge after the accepting edge (4 cycles for WIDTH=16).
REQ-026 From DONE, SHALL return to IDLE on the next edge if start=0, or restart as in REQ-016/REQ-017 if start=1.
REQ-027 sum, cout and ovf SHALL hold their final values from DONE until the next accepting edge; during RUN, sum holds partial results.
REQ-028 Arithmetic SHALL be modulo 2^WIDTH with cout as bit WIDTH; the result SHALL equal a+b+cin for all inputs.
REQ-029 Slice add SHALL be purely combinational within the cycle; no other pipelining is permitted.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE and set busy, done, sum, cout, ovf, the carry register, k and the operand registers to 0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-032 After rst deasserts, the first start SHALL behave per REQ-015 through REQ-025.

Verification
REQ-033 Bench SHALL cover (WIDTH=16): a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; done high exactly 4 cycles after the accepting edge, for 1 cycle.
REQ-034 Bench SHALL cover: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0; carry ripples across all 4 slices.
REQ-035 Bench SHALL cover: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-036 Bench SHALL cover: start=1 with a=0x0001, b=0x0001, then start=1 again in RUN with a=0xAAAA -> second request ignored; result sum=0x0002, busy stays high 4 cycles.
REQ-037 Bench SHALL cover: rst pulsed during the 2nd RUN cycle -> all outputs 0 immediately, no done; a following start with a=0x00FF, b=0x0001 -> sum=0x0100.
REQ-038 Bench SHALL cover: start held high through DONE with new operands a=0x0F0F, b=0x00F1 -> new operation accepted with no IDLE cycle; done deasserts, busy asserts, and the second result is sum=0x1000, cout=0.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two WIDTH-bit operands one 4-bit slice per clock,
// least significant slice first, reporting sum, carry-out and signed overflow.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q, busy_q, done_q;
    logic [KW-1:0]    k_q;

    logic [3:0]       a_sl, b_sl;
    logic [4:0]       slice_d;
    logic             msb_cin_d;
    logic             last_d;

    always_comb begin
        a_sl      = a_q[{k_q, 2'b00} +: 4];
        b_sl      = b_q[{k_q, 2'b00} +: 4];
        slice_d   = {1'b0, a_sl} + {1'b0, b_sl} + {4'b0000, carry_q};
        // carry into bit 3 of the slice recovered from the sum bit
        msb_cin_d = slice_d[3] ^ a_sl[3] ^ b_sl[3];
        last_d    = (k_q == KW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        k_q     <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[{k_q, 2'b00} +: 4] <= slice_d[3:0];
                    carry_q <= slice_d[4];
                    k_q     <= k_q + KW'(1);
                    if (last_d) begin
                        cout_q  <= slice_d[4];
                        ovf_q   <= msb_cin_d ^ slice_d[4];
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed corner cases plus random operands,
// results checked by a queue-based scoreboard against plain wide arithmetic.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int lat;
    int snap;
    logic [17:0] exp_q[$];

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {ovf, cout, sum} from full-width arithmetic
    function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
        logic [16:0] full;
        logic        v;
        full = {1'b0, x} + {1'b0, y} + {16'b0, c};
        v    = (x[15] == y[15]) && (full[15] != x[15]);
        return {v, full};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            logic [17:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: done=1 with no pending operation (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("sum",  {16'b0, sum},  {16'b0, e[15:0]});
                check("cout", {31'b0, cout}, {31'b0, e[16]});
                check("ovf",  {31'b0, ovf},  {31'b0, e[17]});
            end
        end
    end

    // poke >= 0: re-assert start with a=0xAAAA after that many RUN edges
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          input int poke);
        int l, busy_n;
        logic [17:0] e;
        e = ref_add(ta, tb_, tc);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        start = 1'b0;
        l = 0;
        busy_n = 0;
        repeat (12) begin
            if (busy) busy_n++;
            start = (l == poke);
            if (l == poke) a = 16'hAAAA;
            @(posedge clk);
            #1;
            l++;
            if (done) break;
        end
        start = 1'b0;
        check("done_seen", {31'b0, done}, 32'd1);
        check("latency", l, 4);
        check("busy_cycles", busy_n, 4);
        @(posedge clk);
        #1;
        check("done_width", {31'b0, done}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("sum_hold", {16'b0, sum}, {16'b0, e[15:0]});
    endtask

    task automatic wait_done(output int l);
        l = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            l++;
            if (done) break;
        end
    endtask

    initial begin
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sum",  {16'b0, sum},  32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_ovf",  {31'b0, ovf},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b0, -1);
        run_op(16'hFFFF, 16'h0000, 1'b1, -1);
        run_op(16'h7FFF, 16'h0001, 1'b0, -1);
        run_op(16'h8000, 16'h8000, 1'b0, -1);
        run_op(16'h0001, 16'h0001, 1'b0, 1);

        // abort in the second RUN cycle: partial sum must vanish, no done
        @(negedge clk);
        a = 16'h5A5A; b = 16'h0F0F; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        snap = done_cnt;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_sum",  {16'b0, sum},  32'd0);
        check("abort_cout", {31'b0, cout}, 32'd0);
        check("abort_ovf",  {31'b0, ovf},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt, snap);
        run_op(16'h00FF, 16'h0001, 1'b0, -1);

        // start held through DONE: immediate restart with new operands
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(ref_add(16'h1111, 16'h2222, 1'b0));
        #1;
        wait_done(lat);
        check("held_latency", lat, 4);
        a = 16'h0F0F; b = 16'h00F1;
        @(posedge clk);
        exp_q.push_back(ref_add(16'h0F0F, 16'h00F1, 1'b0));
        #1 start = 1'b0;
        check("restart_done", {31'b0, done}, 32'd0);
        check("restart_busy", {31'b0, busy}, 32'd1);
        check("restart_sum_clr", {16'b0, sum}, 32'd0);
        wait_done(lat);
        check("restart_latency", lat, 4);
        check("restart_sum", {16'b0, sum}, 32'h1000);
        check("restart_cout", {31'b0, cout}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), -1);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
